rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter sharing one WIDTH-bit 2:1 mux datapath between two requesters.

---
 rtl/rr_mux_arbiter.sv | 116 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit 2:1 mux between two requesters.
// Latency: a request sampled at edge N is granted after edge N; out is combinational from sel and data.
// Backpressure: a requester keeps its grant while it holds req. Against a waiting peer it keeps it for at most MAX_HOLD cycles.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   req0/req1, in0/in1   level requests and data from requesters 0 and 1
//   gnt0/gnt1            registered one-hot grants (never both high)
//   sel                  registered mux select (0=in0, 1=in1), held while idle
//   out, out_valid       muxed data, registered gnt0|gnt1
module rr_mux_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_nxt;
    logic          last;
    logic          last_nxt;
    logic          sel_nxt;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last;
        sel_nxt   = sel;

        case (state)
            IDLE: begin
                // On a tie, the side that did not own the bus last wins.
                if (req0 && req1)
                    state_nxt = last ? G0 : G1;
                else if (req0)
                    state_nxt = G0;
                else if (req1)
                    state_nxt = G1;
            end
            G0: begin
                if (!req0)
                    state_nxt = req1 ? G1 : IDLE;
                else if (req1 && (hold_cnt == HOLD_LAST))
                    state_nxt = G1;
            end
            G1: begin
                if (!req1)
                    state_nxt = req0 ? G0 : IDLE;
                else if (req0 && (hold_cnt == HOLD_LAST))
                    state_nxt = G0;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt == IDLE) begin
            hold_nxt = '0;
        end else if (state_nxt != state) begin
            // Fresh grant: restart the hold timer and remember the new owner.
            hold_nxt = '0;
            last_nxt = (state_nxt == G1);
        end else if (hold_cnt != HOLD_LAST) begin
            // Saturate so an uncontended owner can hold indefinitely without wrap.
            hold_nxt = hold_cnt + CW'(1);
        end

        // The select only moves when a grant is issued, so IDLE keeps the old path steady.
        if (state_nxt == G0)
            sel_nxt = 1'b0;
        else if (state_nxt == G1)
            sel_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            last      <= 1'b1;
            sel       <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            last      <= last_nxt;
            sel       <= sel_nxt;
            gnt0      <= (state_nxt == G0);
            gnt1      <= (state_nxt == G1);
            out_valid <= (state_nxt != IDLE);
        end
    end

    assign out = sel ? in1 : in0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: default MAX_HOLD=4 instance plus a MAX_HOLD=1 instance.
// Expected grant/select patterns are queued when stimulus is driven and checked one cycle later.
// Both instances share clock, reset, requests and data.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [3:0] in0;
    logic [3:0] in1;

    logic       a_gnt0, a_gnt1, a_sel, a_valid;
    logic [3:0] a_out;
    logic       b_gnt0, b_gnt1, b_sel, b_valid;
    logic [3:0] b_out;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .in0(in0), .in1(in1), .gnt0(a_gnt0), .gnt1(a_gnt1),
        .sel(a_sel), .out(a_out), .out_valid(a_valid)
    );

    rr_mux_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .in0(in0), .in1(in1), .gnt0(b_gnt0), .gnt1(b_gnt1),
        .sel(b_sel), .out(b_out), .out_valid(b_valid)
    );

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       s;
        logic [3:0] o;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_a(input logic g0, input logic g1, input logic s);
        exp_t e;
        e.g0 = g0;
        e.g1 = g1;
        e.s  = s;
        e.o  = s ? in1 : in0;
        qa.push_back(e);
    endtask

    task automatic expect_b(input logic g0, input logic g1, input logic s);
        exp_t e;
        e.g0 = g0;
        e.g1 = g1;
        e.s  = s;
        e.o  = s ? in1 : in0;
        qb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        while (qa.size() > 0) begin
            e = qa.pop_front();
            chk({tag, ".a.gnt0"},  {7'd0, a_gnt0},  {7'd0, e.g0});
            chk({tag, ".a.gnt1"},  {7'd0, a_gnt1},  {7'd0, e.g1});
            chk({tag, ".a.sel"},   {7'd0, a_sel},   {7'd0, e.s});
            chk({tag, ".a.valid"}, {7'd0, a_valid}, {7'd0, e.g0 | e.g1});
            chk({tag, ".a.out"},   {4'd0, a_out},   {4'd0, e.o});
            chk({tag, ".a.excl"},  {7'd0, a_gnt0 & a_gnt1}, 8'd0);
        end
        while (qb.size() > 0) begin
            e = qb.pop_front();
            chk({tag, ".b.gnt0"},  {7'd0, b_gnt0},  {7'd0, e.g0});
            chk({tag, ".b.gnt1"},  {7'd0, b_gnt1},  {7'd0, e.g1});
            chk({tag, ".b.sel"},   {7'd0, b_sel},   {7'd0, e.s});
            chk({tag, ".b.valid"}, {7'd0, b_valid}, {7'd0, e.g0 | e.g1});
            chk({tag, ".b.out"},   {4'd0, b_out},   {4'd0, e.o});
            chk({tag, ".b.excl"},  {7'd0, b_gnt0 & b_gnt1}, 8'd0);
        end
    endtask

    initial begin
        // Reset held two cycles with both requesting: nothing granted, out follows in0.
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; in0 = 4'h3; in1 = 4'hC;
        repeat (2) begin
            expect_a(1'b0, 1'b0, 1'b0);
            tick("reset");
        end

        // Single uncontended requester: grant next cycle, held beyond MAX_HOLD.
        rst_n = 1'b1; req1 = 1'b0; in0 = 4'b0101;
        repeat (11) begin
            expect_a(1'b1, 1'b0, 1'b0);
            tick("single");
        end
        req0 = 1'b0;
        expect_a(1'b0, 1'b0, 1'b0);
        tick("single_drop");

        // Tie straight after reset: req0 first, rotation every 4 cycles.
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        expect_a(1'b0, 1'b0, 1'b0);
        tick("tie_rst");
        rst_n = 1'b1; in0 = 4'h0; in1 = 4'hF;
        for (int i = 0; i < 13; i++) begin
            logic g0;
            g0 = ((i / 4) % 2) == 0;
            expect_a(g0, !g0, !g0);
            tick("tie_rot");
        end

        // Now in G1 (freshly rotated); owner drops with req0 waiting: direct handover.
        req1 = 1'b0;
        expect_a(1'b1, 1'b0, 1'b0);
        tick("handover");

        // Move to G1 and let hold_cnt reach 2, then reset mid-grant.
        req0 = 1'b0; req1 = 1'b1;
        repeat (3) begin
            expect_a(1'b0, 1'b1, 1'b1);
            tick("g1_hold");
        end
        rst_n = 1'b0; req0 = 1'b1;
        expect_a(1'b0, 1'b0, 1'b0);
        tick("mid_rst");
        rst_n = 1'b1;
        expect_a(1'b1, 1'b0, 1'b0);
        tick("post_rst_g0");

        // Going idle from G1 keeps sel at 1, so out tracks in1.
        req0 = 1'b0;
        expect_a(1'b0, 1'b1, 1'b1);
        tick("to_g1");
        req1 = 1'b0; in0 = 4'h2; in1 = 4'h9;
        expect_a(1'b0, 1'b0, 1'b1);
        tick("idle_sel_hold");

        // MAX_HOLD=1 instance: contended grants alternate every cycle.
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; in0 = 4'hA; in1 = 4'h5;
        expect_b(1'b0, 1'b0, 1'b0);
        tick("mh1_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic g0;
            g0 = (i % 2) == 0;
            expect_b(g0, !g0, !g0);
            tick("mh1_alt");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
